// File: rtl/instruction_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : instruction_fetch_unit
// Description : Single-outstanding instruction fetch engine with an in-order
//               fetch buffer. Handles decode redirects by flushing buffered
//               words and discarding any in-flight response.
// Revision    : 1.0 - initial release
// ============================================================================
module instruction_fetch_unit #(
    parameter logic [31:0] RESET_VECTOR = 32'h00400000,
    parameter int          BUF_DEPTH    = 2
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        Redirect,
    input  logic [31:0] Redirect_Address,
    output logic        IMem_Req,
    output logic [31:0] IMem_Addr,
    input  logic        IMem_Ack,
    input  logic [31:0] IMem_Data,
    output logic        Out_Valid,
    input  logic        Out_Ready,
    output logic [31:0] Out_Instruction,
    output logic [31:0] Out_PC_Plus4
);

    localparam int               PTR_W     = (BUF_DEPTH > 2) ? 2 : 1;
    localparam int               CNT_W     = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(BUF_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DROP = 2'd2
    } state_t;

    state_t             state;
    logic [31:0]        fpc;
    logic [31:0]        rpc;
    logic [31:0]        fifo_instr [BUF_DEPTH];
    logic [31:0]        fifo_pc4   [BUF_DEPTH];
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W-1:0]   wr_ptr;
    logic [CNT_W-1:0]   count;

    logic [31:0]        target;
    logic [31:0]        next_seq;
    logic               has_space;
    logic               ack;
    logic               push;
    logic               pop;

    // Low target bits are word-offset noise from the next-PC calculation
    wire unused_addr_bits = &{1'b0, Redirect_Address[1:0]};

    // Request generation: IDLE issues from FPC when there is room, WAIT/DROP hold RPC
    always_comb begin
        target    = {Redirect_Address[31:2], 2'b00};
        has_space = (count < DEPTH_CNT);
        IMem_Req  = 1'b0;
        IMem_Addr = fpc;
        if (RESET) begin
            IMem_Req  = 1'b0;
            IMem_Addr = 32'd0;
        end else if (state == ST_IDLE) begin
            IMem_Req  = has_space & ~Redirect;
            IMem_Addr = fpc;
        end else begin
            IMem_Req  = 1'b1;
            IMem_Addr = rpc;
        end
        // Sequential successor of the address on the bus; wraps modulo 2^32
        next_seq  = IMem_Addr + 32'd4;
        // An ack only counts against a live request
        ack       = IMem_Ack & IMem_Req;
        push      = ack & ~Redirect & (state != ST_DROP);
        Out_Valid = (count != '0) & ~Redirect & ~RESET;
        pop       = Out_Valid & Out_Ready;
        Out_Instruction = RESET ? 32'd0 : fifo_instr[rd_ptr];
        Out_PC_Plus4    = RESET ? 32'd0 : fifo_pc4[rd_ptr];
    end

    // Fetch FSM together with the fetch-PC and pending-address registers
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state <= ST_IDLE;
            fpc   <= RESET_VECTOR;
            rpc   <= 32'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (Redirect) begin
                        fpc <= target;
                    end else if (IMem_Req) begin
                        rpc <= fpc;
                        if (ack) begin
                            fpc <= next_seq;
                        end else begin
                            state <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (ack) begin
                        state <= ST_IDLE;
                        fpc   <= Redirect ? target : next_seq;
                    end else if (Redirect) begin
                        fpc   <= target;
                        state <= ST_DROP;
                    end
                end
                ST_DROP: begin
                    // Newest redirect wins; the stale response is simply absorbed
                    if (Redirect) begin
                        fpc <= target;
                    end
                    if (ack) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Fetch buffer: in-order FIFO, flushed wholesale on any redirect
    always_ff @(posedge CLK) begin
        if (RESET) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < BUF_DEPTH; i++) begin
                fifo_instr[i] <= 32'd0;
                fifo_pc4[i]   <= 32'd0;
            end
        end else if (Redirect) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                fifo_instr[wr_ptr] <= IMem_Data;
                fifo_pc4[wr_ptr]   <= next_seq;
                wr_ptr             <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push && !pop) begin
                count <= count + CNT_W'(1);
            end else if (pop && !push) begin
                count <= count - CNT_W'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_instruction_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_instruction_fetch_unit
// Description : Self-checking bench for instruction_fetch_unit. A memory
//               responder with programmable latency feeds the DUT and an
//               instruction-stream model predicts every word decode receives.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instruction_fetch_unit;

    localparam logic [31:0] RV  = 32'h00400000;
    localparam logic [31:0] KEY = 32'hDEADBEEF;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic        Redirect = 1'b0;
    logic [31:0] Redirect_Address = 32'd0;
    logic        IMem_Req;
    logic [31:0] IMem_Addr;
    logic        IMem_Ack = 1'b0;
    logic [31:0] IMem_Data = 32'd0;
    logic        Out_Valid;
    logic        Out_Ready = 1'b0;
    logic [31:0] Out_Instruction;
    logic [31:0] Out_PC_Plus4;

    int          checks = 0;
    int          passed = 0;

    // Memory responder state
    int          latency = 1;
    bit          spurious = 1'b0;
    int          waited = 0;
    bit          outstanding = 1'b0;
    logic [31:0] out_addr = 32'd0;
    int          starts = 0;
    logic [31:0] last_start = 32'd0;
    bit          s_ack = 1'b0;
    bit          s_valid = 1'b0;

    // Stream model: the PC decode must receive next
    logic [31:0] exp_pc = RV;
    int          pops = 0;
    logic [31:0] last_pop_pc4 = 32'd0;
    logic [31:0] last_pop_instr = 32'd0;

    always #5 CLK = ~CLK;

    instruction_fetch_unit dut (
        .CLK              (CLK),
        .RESET            (RESET),
        .Redirect         (Redirect),
        .Redirect_Address (Redirect_Address),
        .IMem_Req         (IMem_Req),
        .IMem_Addr        (IMem_Addr),
        .IMem_Ack         (IMem_Ack),
        .IMem_Data        (IMem_Data),
        .Out_Valid        (Out_Valid),
        .Out_Ready        (Out_Ready),
        .Out_Instruction  (Out_Instruction),
        .Out_PC_Plus4     (Out_PC_Plus4)
    );

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %08h expected %08h", name, act, exp);
    endfunction

    // Per-cycle compare, stream model update and memory response
    always @(negedge CLK) begin
        if (RESET) begin
            check("reset_req",   32'(IMem_Req), 32'd0);
            check("reset_valid", 32'(Out_Valid), 32'd0);
            check("reset_addr",  IMem_Addr, 32'd0);
            check("reset_instr", Out_Instruction, 32'd0);
            check("reset_pc4",   Out_PC_Plus4, 32'd0);
            exp_pc      = RV;
            outstanding = 1'b0;
            waited      = 0;
            IMem_Ack    = 1'b0;
            s_ack       = 1'b0;
            s_valid     = 1'b0;
        end else begin
            if (Redirect) begin
                check("redirect_valid", 32'(Out_Valid), 32'd0);
                exp_pc = Redirect_Address & ~32'd3;
            end else if (Out_Valid && Out_Ready) begin
                check("stream_pc4",   Out_PC_Plus4, exp_pc + 32'd4);
                check("stream_instr", Out_Instruction, exp_pc ^ KEY);
                last_pop_pc4   = Out_PC_Plus4;
                last_pop_instr = Out_Instruction;
                exp_pc = exp_pc + 32'd4;
                pops++;
            end
            IMem_Ack = 1'b0;
            s_ack    = 1'b0;
            if (IMem_Req) begin
                check("addr_align", 32'(IMem_Addr[1:0]), 32'd0);
                if (outstanding) begin
                    check("addr_stable", IMem_Addr, out_addr);
                end else begin
                    starts++;
                    last_start = IMem_Addr;
                    waited = 0;
                end
                if (waited >= latency) begin
                    IMem_Ack    = 1'b1;
                    IMem_Data   = IMem_Addr ^ KEY;
                    outstanding = 1'b0;
                    s_ack       = 1'b1;
                end else begin
                    waited++;
                    outstanding = 1'b1;
                    out_addr    = IMem_Addr;
                end
            end else begin
                if (outstanding) check("req_held", 32'(IMem_Req), 32'd1);
                if (spurious) begin
                    IMem_Ack  = 1'b1;
                    IMem_Data = 32'hBAD0BAD0;
                end
            end
            s_valid = Out_Valid;
        end
    end

    task automatic wait_pops(input int k, input int budget);
        int target = pops + k;
        int t = 0;
        while (pops < target && t < budget) begin
            @(posedge CLK);
            t++;
        end
        check("pop_timeout", 32'(pops >= target), 32'd1);
    endtask

    task automatic wait_start(input int budget);
        int s = starts;
        int t = 0;
        while (starts == s && t < budget) begin
            @(posedge CLK);
            t++;
        end
        check("start_timeout", 32'(starts != s), 32'd1);
    endtask

    initial begin
        int p;
        int t;
        // Reset and first fetch
        repeat (3) @(posedge CLK);
        #1 RESET = 1'b0;
        Out_Ready = 1'b1;
        @(negedge CLK);
        check("first_req",  32'(IMem_Req), 32'd1);
        check("first_addr", IMem_Addr, RV);

        // Streaming with 1-cycle memory
        wait_pops(1, 10);
        check("stream_first_pc4",   last_pop_pc4, 32'h00400004);
        check("stream_first_instr", last_pop_instr, 32'hDEEDBEEF);
        wait_pops(1, 10);
        check("stream_second_pc4",  last_pop_pc4, 32'h00400008);
        p = pops;
        repeat (20) @(posedge CLK);
        check("stream_rate", 32'(pops - p), 32'd10);

        // Backpressure with stray acks while no request is live
        #1 Out_Ready = 1'b0;
        spurious = 1'b1;
        repeat (10) @(posedge CLK);
        #2;
        check("bp_req",   32'(IMem_Req), 32'd0);
        check("bp_valid", 32'(Out_Valid), 32'd1);
        check("bp_head_pc4",   Out_PC_Plus4, exp_pc + 32'd4);
        check("bp_head_instr", Out_Instruction, exp_pc ^ KEY);
        @(posedge CLK);
        #1 Out_Ready = 1'b1;
        spurious = 1'b0;
        p = pops;
        repeat (2) @(posedge CLK);
        check("bp_drain_burst", 32'(pops - p), 32'd2);

        // Zero-wait memory
        #1 latency = 0;
        p = pops;
        repeat (20) @(posedge CLK);
        check("zero_wait_rate", 32'(pops - p >= 15), 32'd1);

        // Redirect in WAIT, then a newer redirect while dropping
        #1 latency = 3;
        wait_start(20);
        #1 Redirect = 1'b1;
        Redirect_Address = 32'h00400080;
        @(posedge CLK);
        #1 Redirect_Address = 32'h00400100;
        @(posedge CLK);
        #1 Redirect = 1'b0;
        wait_start(20);
        check("redirect_fetch_addr", last_start, 32'h00400100);
        wait_pops(1, 20);
        check("redirect_first_pc4", last_pop_pc4, 32'h00400104);

        // Redirect coincident with ack and a ready decode
        #1 latency = 1;
        Out_Ready = 1'b0;
        t = 0;
        while (!(s_valid && outstanding) && t < 30) begin
            @(posedge CLK);
            t++;
        end
        check("coincident_setup", 32'(s_valid && outstanding), 32'd1);
        #1 Redirect = 1'b1;
        Redirect_Address = 32'h00400200;
        Out_Ready = 1'b1;
        @(negedge CLK);
        #1;
        check("coincident_ack",   32'(s_ack), 32'd1);
        check("coincident_valid", 32'(Out_Valid), 32'd0);
        @(posedge CLK);
        #1 Redirect = 1'b0;
        @(negedge CLK);
        #1;
        check("flush_empty", 32'(Out_Valid), 32'd0);
        check("flush_req",   32'(IMem_Req), 32'd1);
        check("flush_addr",  IMem_Addr, 32'h00400200);
        wait_pops(1, 20);
        check("flush_first_pc4", last_pop_pc4, 32'h00400204);

        // Redirect to the top of the address space, PC+4 wraps
        @(posedge CLK);
        #1 Redirect = 1'b1;
        Redirect_Address = 32'hFFFFFFFF;
        @(posedge CLK);
        #1 Redirect = 1'b0;
        wait_start(20);
        check("wrap_fetch_addr", last_start, 32'hFFFFFFFC);
        wait_pops(1, 20);
        check("wrap_pc4",   last_pop_pc4, 32'h00000000);
        check("wrap_instr", last_pop_instr, 32'h21524113);
        wait_pops(1, 20);
        check("wrap_next_pc4", last_pop_pc4, 32'h00000004);

        // Reset while a request is outstanding
        #1 latency = 3;
        wait_start(20);
        #1 RESET = 1'b1;
        @(negedge CLK);
        #1;
        check("rst_wait_req",   32'(IMem_Req), 32'd0);
        check("rst_wait_valid", 32'(Out_Valid), 32'd0);
        @(posedge CLK);
        #1 RESET = 1'b0;
        latency = 1;
        @(negedge CLK);
        check("rst_after_req",  32'(IMem_Req), 32'd1);
        check("rst_after_addr", IMem_Addr, RV);
        wait_pops(1, 20);
        check("rst_after_pc4", last_pop_pc4, 32'h00400004);

        repeat (4) @(posedge CLK);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/instruction_fetch_unit.md
INSTRUCTION_FETCH_UNIT -- requirements
Module: instruction_fetch_unit

Interface
REQ-001 Parameter RESET_VECTOR, default 32'h00400000, is the first fetch address after reset.
REQ-002 Parameter BUF_DEPTH, default 2, is the number of fetch-buffer entries; legal values are 2 or 4.
REQ-003 CLK  in  1  sole clock; all state updates on rising edge.
REQ-004 RESET  in  1  synchronous, active-high reset.
REQ-005 Redirect  in  1  decode-stage jump/branch taken; load new fetch PC.
REQ-006 Redirect_Address  in  32  target from next-instruction calculation; bits [1:0] ignored.
REQ-007 IMem_Req  out  1  instruction-memory read request.
REQ-008 IMem_Addr  out  32  word address of request; bits [1:0] always 0.
REQ-009 IMem_Ack  in  1  read complete; IMem_Data valid this cycle.
REQ-010 IMem_Data  in  32  fetched instruction word.
REQ-011 Out_Valid  out  1  buffer head holds a valid instruction for decode.
REQ-012 Out_Ready  in  1  decode accepts the head this cycle.
REQ-013 Out_Instruction  out  32  head instruction bits.
REQ-014 Out_PC_Plus4  out  32  head instruction PC + 4.

Function
REQ-015 The fetch PC (FPC) register shall hold the next address to fetch; the pending-address register (RPC) shall hold the address of the outstanding request.
REQ-016 The FSM states shall be IDLE (no request outstanding), WAIT (request outstanding, result kept) and DROP (request outstanding, result discarded).
REQ-017 IDLE: when buffer count < BUF_DEPTH and Redirect=0, IMem_Req=1 with IMem_Addr=FPC; RPC<=FPC; next state WAIT, or remain IDLE if IMem_Ack arrives the same cycle.
REQ-018 WAIT and DROP: IMem_Req=1 and IMem_Addr=RPC held stable until the IMem_Ack cycle; at most one request is outstanding.
REQ-019 WAIT with IMem_Ack and no Redirect: push {IMem_Data, RPC+4}; FPC<=RPC+4; next state IDLE.
REQ-020 A zero-wait ack in IDLE shall be handled exactly as REQ-019.
REQ-021 Redirect in IDLE: FPC<={Redirect_Address[31:2],2'b00}; flush buffer; issue no request that cycle; remain IDLE.
REQ-022 Redirect in WAIT without IMem_Ack: FPC<=target; flush; next state DROP.
REQ-023 Redirect coincident with IMem_Ack in any state: discard returned data; FPC<=target; flush; next state IDLE.
REQ-024 DROP with IMem_Ack: discard data; next state IDLE. A Redirect in DROP shall overwrite FPC with the newest target.
REQ-025 Buffer: in-order FIFO of BUF_DEPTH entries with a count register; a push when full shall not occur, because issue is gated per REQ-017.
REQ-026 Out_Valid = (count != 0) & ~Redirect; a pop occurs when Out_Valid & Out_Ready; push and pop in the same cycle leave count unchanged.
REQ-027 Out_Instruction and Out_PC_Plus4 shall come from the FIFO head with no bypass, so an acked word is visible the cycle after IMem_Ack.
REQ-028 Instruction order is preserved. There is no delay slot: Redirect discards every buffered and in-flight instruction.
REQ-029 PC+4 arithmetic is modulo 2^32, so 32'hFFFFFFFC+4 = 0.
REQ-030 IMem_Ack while IMem_Req=0 shall be ignored.

Reset
REQ-031 While RESET=1: FPC<=RESET_VECTOR, RPC<=0, state<=IDLE, count<=0, FIFO entries<=0; IMem_Req=0 and Out_Valid=0.
REQ-032 Out_Instruction=0, Out_PC_Plus4=0 and IMem_Addr=0 during reset.
REQ-033 Reset mid-request shall abandon the request; instruction memory shares RESET and drops it.
REQ-034 The first cycle after reset deasserts shall show IMem_Req=1 and IMem_Addr=RESET_VECTOR.

Verification
REQ-035 Stream: 1-cycle-latency memory, Out_Ready=1 -> Out_PC_Plus4 sequence 00400004, 00400008, ...; one instruction per 2 cycles; data matches memory.
REQ-036 Backpressure: Out_Ready=0 for 10 cycles -> count saturates at BUF_DEPTH, IMem_Req=0, head stable; release -> no loss or duplicate.
REQ-037 Redirect in WAIT to 0x00400100, ack 3 cycles later -> acked word dropped; next Out_PC_Plus4 = 00400104; next IMem_Addr = 00400100.
REQ-038 Redirect coincident with IMem_Ack and a pop -> Out_Valid=0 that cycle; buffer empty; next IMem_Addr = target.
REQ-039 Redirect to 32'hFFFFFFFF -> IMem_Addr=FFFFFFFC, Out_PC_Plus4=00000000; RESET asserted in WAIT -> next cycle IMem_Req=0, Out_Valid=0.
